// File: rtl/sat_counter.sv
// Saturating / wrapping up-down counter with an inclusive runtime limit.
// Define SAT_COUNTER_STICKY_EN to build in the sticky blocked-step flag.
module sat_counter #(
   parameter int              WIDTH = 8,
   parameter longint unsigned STEP  = 1
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_en,
   input  logic             i_up,
   input  logic             i_mode,
   input  logic [WIDTH-1:0] i_limit,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_clr_sticky,
   output logic [WIDTH-1:0] o_count,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_wrap,
   output logic             o_sticky_sat
);

   localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             blocked;
   logic [WIDTH:0]   count_x, limit_x, sum_x, diff_x;

   assign count_x = {1'b0, count_q};
   assign limit_x = {1'b0, i_limit};
   assign sum_x   = count_x + STEP_X;
   // Borrow out of the extra top bit marks count < STEP.
   assign diff_x  = count_x - STEP_X;

   assign o_full  = (count_q == i_limit);
   assign o_empty = (count_q == '0);
   assign o_count = count_q;
   assign o_wrap  = wrap_q;

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      blocked = 1'b0;
      if (i_load) begin
         count_d = (i_load_val > i_limit) ? i_limit : i_load_val;
      end else if (count_q > i_limit) begin
         count_d = i_limit;
      end else if (i_en) begin
         if (i_up) begin
            blocked = !i_mode && o_full;
            if (sum_x > limit_x) begin
               if (i_mode) begin
                  count_d = '0;
                  wrap_d  = 1'b1;
               end else begin
                  count_d = i_limit;
               end
            end else begin
               count_d = sum_x[WIDTH-1:0];
            end
         end else begin
            blocked = !i_mode && o_empty;
            if (diff_x[WIDTH]) begin
               if (i_mode) begin
                  count_d = i_limit;
                  wrap_d  = 1'b1;
               end else begin
                  count_d = '0;
               end
            end else begin
               count_d = diff_x[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

`ifdef SAT_COUNTER_STICKY_EN
   logic sticky_q, sticky_d;

   always_comb begin
      sticky_d = sticky_q;
      if (blocked)           sticky_d = 1'b1;
      else if (i_clr_sticky) sticky_d = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) sticky_q <= 1'b0;
      else         sticky_q <= sticky_d;
   end

   assign o_sticky_sat = sticky_q;
`else
   logic unused_sticky;
   assign unused_sticky = i_clr_sticky ^ blocked;
   assign o_sticky_sat  = 1'b0;
`endif

endmodule

// File: tb/tb_sat_counter.sv
// Directed bench for sat_counter: vector table on a STEP=3 instance plus
// multi-cycle sequences on STEP=1 and STEP=4 instances sharing the inputs.
module tb_sat_counter;

`ifdef SAT_COUNTER_STICKY_EN
   localparam logic STICKY = 1'b1;
`else
   localparam logic STICKY = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rstn, en, up, mode, load, clr;
   logic [7:0] limit, load_val;

   logic [7:0] cnt1, cnt3, cnt4;
   logic       full1, full3, full4, empty1, empty3, empty4;
   logic       wrap1, wrap3, wrap4, stk1, stk3, stk4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sat_counter #(.WIDTH(8), .STEP(1)) u_dut1 (
      .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_up(up), .i_mode(mode),
      .i_limit(limit), .i_load(load), .i_load_val(load_val), .i_clr_sticky(clr),
      .o_count(cnt1), .o_full(full1), .o_empty(empty1), .o_wrap(wrap1), .o_sticky_sat(stk1));

   sat_counter #(.WIDTH(8), .STEP(3)) u_dut3 (
      .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_up(up), .i_mode(mode),
      .i_limit(limit), .i_load(load), .i_load_val(load_val), .i_clr_sticky(clr),
      .o_count(cnt3), .o_full(full3), .o_empty(empty3), .o_wrap(wrap3), .o_sticky_sat(stk3));

   sat_counter #(.WIDTH(8), .STEP(4)) u_dut4 (
      .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_up(up), .i_mode(mode),
      .i_limit(limit), .i_load(load), .i_load_val(load_val), .i_clr_sticky(clr),
      .o_count(cnt4), .o_full(full4), .o_empty(empty4), .o_wrap(wrap4), .o_sticky_sat(stk4));

   typedef struct {
      logic       rstn, en, up, mode, load;
      logic [7:0] limit, load_val;
      logic [7:0] e_count;
      logic       e_wrap, e_full, e_empty;
   } vec_t;

   vec_t vecs[26];

   function automatic vec_t mk(logic r, logic e, logic u, logic m, logic ld,
                               logic [7:0] lim, logic [7:0] lv,
                               logic [7:0] ec, logic ew, logic ef, logic ee);
      vec_t v;
      v.rstn = r; v.en = e; v.up = u; v.mode = m; v.load = ld;
      v.limit = lim; v.load_val = lv;
      v.e_count = ec; v.e_wrap = ew; v.e_full = ef; v.e_empty = ee;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0; en = 1'b0; up = 1'b1; mode = 1'b0; load = 1'b0; clr = 1'b0;
      limit = 8'd10; load_val = 8'd0;

      //               rst en up md ld lim   lv    cnt   w  f  e
      vecs[0]  = mk(0, 0, 1, 1, 0, 8'd10,  8'd0,  8'd0,  0, 0, 1);
      vecs[1]  = mk(1, 1, 1, 1, 0, 8'd10,  8'd0,  8'd3,  0, 0, 0);
      vecs[2]  = mk(1, 1, 1, 1, 0, 8'd10,  8'd0,  8'd6,  0, 0, 0);
      vecs[3]  = mk(1, 1, 1, 1, 0, 8'd10,  8'd0,  8'd9,  0, 0, 0);
      vecs[4]  = mk(1, 1, 1, 1, 0, 8'd10,  8'd0,  8'd0,  1, 0, 1);
      vecs[5]  = mk(1, 1, 1, 1, 0, 8'd10,  8'd0,  8'd3,  0, 0, 0);
      vecs[6]  = mk(1, 1, 1, 0, 0, 8'd10,  8'd0,  8'd6,  0, 0, 0);
      vecs[7]  = mk(1, 1, 1, 0, 0, 8'd10,  8'd0,  8'd9,  0, 0, 0);
      vecs[8]  = mk(1, 1, 1, 0, 0, 8'd10,  8'd0,  8'd10, 0, 1, 0);
      vecs[9]  = mk(1, 1, 1, 0, 0, 8'd10,  8'd0,  8'd10, 0, 1, 0);
      vecs[10] = mk(1, 1, 0, 0, 0, 8'd10,  8'd0,  8'd7,  0, 0, 0);
      vecs[11] = mk(1, 1, 1, 0, 1, 8'd255, 8'd200, 8'd200, 0, 0, 0);
      vecs[12] = mk(1, 0, 1, 0, 0, 8'd50,  8'd0,  8'd50, 0, 1, 0);
      vecs[13] = mk(1, 0, 1, 0, 1, 8'd50,  8'd90, 8'd50, 0, 1, 0);
      vecs[14] = mk(1, 1, 1, 1, 0, 8'd0,   8'd0,  8'd0,  0, 1, 1);
      vecs[15] = mk(1, 1, 1, 1, 0, 8'd0,   8'd0,  8'd0,  1, 1, 1);
      vecs[16] = mk(1, 1, 1, 1, 0, 8'd0,   8'd0,  8'd0,  1, 1, 1);
      vecs[17] = mk(1, 1, 0, 1, 0, 8'd0,   8'd0,  8'd0,  1, 1, 1);
      vecs[18] = mk(1, 1, 0, 0, 0, 8'd0,   8'd0,  8'd0,  0, 1, 1);
      vecs[19] = mk(1, 1, 0, 1, 1, 8'd20,  8'd2,  8'd2,  0, 0, 0);
      vecs[20] = mk(1, 1, 0, 1, 0, 8'd20,  8'd0,  8'd20, 1, 1, 0);
      vecs[21] = mk(1, 1, 0, 0, 0, 8'd20,  8'd0,  8'd17, 0, 0, 0);
      vecs[22] = mk(1, 0, 1, 0, 1, 8'd20,  8'd5,  8'd5,  0, 0, 0);
      vecs[23] = mk(1, 1, 1, 0, 1, 8'd20,  8'd7,  8'd7,  0, 0, 0);
      vecs[24] = mk(1, 0, 0, 0, 0, 8'd20,  8'd0,  8'd7,  0, 0, 0);
      vecs[25] = mk(0, 1, 1, 0, 1, 8'd20,  8'd9,  8'd0,  0, 0, 1);

      for (int i = 0; i < 26; i++) begin
         rstn = vecs[i].rstn; en = vecs[i].en; up = vecs[i].up; mode = vecs[i].mode;
         load = vecs[i].load; limit = vecs[i].limit; load_val = vecs[i].load_val;
         tick();
         check($sformatf("vec%0d count", i), cnt3,   vecs[i].e_count);
         check($sformatf("vec%0d wrap", i),  wrap3,  vecs[i].e_wrap);
         check($sformatf("vec%0d full", i),  full3,  vecs[i].e_full);
         check($sformatf("vec%0d empty", i), empty3, vecs[i].e_empty);
      end

      // Reset during a wrapping step discards the pulse; next step starts from 0.
      rstn = 1'b1; en = 1'b0; load = 1'b1; load_val = 8'd9; limit = 8'd10; mode = 1'b1; up = 1'b1;
      tick();
      check("pre-rst load", cnt3, 8'd9);
      rstn = 1'b0; load = 1'b0; en = 1'b1;
      tick();
      check("rst-wrap count", cnt3, 8'd0);
      check("rst-wrap wrap", wrap3, 1'b0);
      check("rst-wrap sticky", stk3, 1'b0);
      rstn = 1'b1;
      tick();
      check("post-rst count", cnt3, 8'd3);
      check("post-rst wrap", wrap3, 1'b0);

      // STEP=4 down from 2, limit 20: wrap mode then saturate mode.
      en = 1'b0; load = 1'b1; load_val = 8'd2; limit = 8'd20;
      tick();
      check("s4 load", cnt4, 8'd2);
      load = 1'b0; en = 1'b1; up = 1'b0; mode = 1'b1;
      tick();
      check("s4 wrapdn count", cnt4, 8'd20);
      check("s4 wrapdn wrap", wrap4, 1'b1);
      en = 1'b0;
      tick();
      check("s4 wrap one-shot", wrap4, 1'b0);
      check("s4 hold", cnt4, 8'd20);
      load = 1'b1; load_val = 8'd2;
      tick();
      load = 1'b0; en = 1'b1; mode = 1'b0;
      tick();
      check("s4 satdn count", cnt4, 8'd0);
      check("s4 satdn wrap", wrap4, 1'b0);

      // STEP=1 long saturating climb to 255 with sticky flag.
      rstn = 1'b0; en = 1'b0; up = 1'b1; mode = 1'b0; limit = 8'd255; load = 1'b0; clr = 1'b0;
      tick();
      check("s1 rst sticky", stk1, 1'b0);
      check("s1 rst empty", empty1, 1'b1);
      check("s1 rst full", full1, 1'b0);
      rstn = 1'b1; en = 1'b1;
      for (int c = 1; c <= 300; c++) begin
         tick();
         if (c == 254) begin
            check("s1 c254 count", cnt1, 8'd254);
            check("s1 c254 full", full1, 1'b0);
         end
         if (c == 255) begin
            check("s1 c255 count", cnt1, 8'd255);
            check("s1 c255 full", full1, 1'b1);
            check("s1 c255 sticky", stk1, 1'b0);
         end
      end
      check("s1 c300 count", cnt1, 8'd255);
      check("s1 c300 full", full1, 1'b1);
      check("s1 c300 sticky", stk1, STICKY);

      clr = 1'b1;
      tick();
      check("sticky set+clr", stk1, STICKY);
      en = 1'b0;
      tick();
      check("sticky clr alone", stk1, 1'b0);
      check("s1 stable", cnt1, 8'd255);
      clr = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
